// File: rtl/dmem_unit.sv
// dmem_unit: CPU data memory with byte-lane stores, extended loads, misalignment detection
// and a sticky error log. Optional memory-mapped LED/switch window: DMEM_MMIO_EN.
module dmem_unit #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] dout,
  output logic        misalign,
  output logic [7:0]  err_cnt,
  output logic [31:0] err_addr
`ifdef DMEM_MMIO_EN
  ,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
`endif
);

  localparam int WORDS = 2 ** ADDR_W;

  logic [31:0]       mem_q [WORDS];
  logic [ADDR_W-1:0] word_idx_s;
  logic              is_word_s, is_half_s, is_byte_s, legal_s, misalign_s;
  logic              hit_s, wr_en_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s, rd_word_s, ram_rd_s, mmio_rd_s;
  logic [15:0]       half_s;
  logic [7:0]        byte_s;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [31:0]       err_addr_q, err_addr_d;

  // Upper address bits are ignored, so the RAM aliases modulo its size.
  assign word_idx_s = addr[ADDR_W+1:2];
  assign rd_word_s  = mem_q[word_idx_s];

  always_comb begin
    is_word_s = 1'b0;
    is_half_s = 1'b0;
    is_byte_s = 1'b0;
    case (dm_ctrl)
      3'b000:         is_word_s = 1'b1;
      3'b001, 3'b010: is_half_s = 1'b1;
      3'b011, 3'b100: is_byte_s = 1'b1;
      default:        is_word_s = 1'b0;
    endcase
    legal_s    = is_word_s | is_half_s | is_byte_s;
    misalign_s = (is_word_s && (addr[1:0] != 2'b00)) || (is_half_s && addr[0]);
  end

  always_comb begin
    half_s = addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    case (addr[1:0])
      2'b00:   byte_s = rd_word_s[7:0];
      2'b01:   byte_s = rd_word_s[15:8];
      2'b10:   byte_s = rd_word_s[23:16];
      default: byte_s = rd_word_s[31:24];
    endcase
    case (dm_ctrl)
      3'b000:  ram_rd_s = rd_word_s;
      3'b001:  ram_rd_s = {{16{half_s[15]}}, half_s};
      3'b010:  ram_rd_s = {16'h0000, half_s};
      3'b011:  ram_rd_s = {{24{byte_s[7]}}, byte_s};
      3'b100:  ram_rd_s = {24'h00_0000, byte_s};
      default: ram_rd_s = 32'h0000_0000;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = din;
    if (is_word_s) begin
      be_s = 4'b1111;
    end else if (is_half_s) begin
      be_s    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_s = {2{din[15:0]}};
    end else if (is_byte_s) begin
      be_s    = 4'b0001 << addr[1:0];
      wdata_s = {4{din[7:0]}};
    end else begin
      be_s = 4'b0000;
    end
    wr_en_s = mem_w && legal_s && !misalign_s && !hit_s;
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) mem_q[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
      end
    end
  end

`ifdef DMEM_MMIO_EN
  logic [15:0] led_q, led_d, sw_meta_q, sw_sync_q;

  always_comb begin
    hit_s     = (addr[31:16] == MMIO_BASE[31:16]);
    led_d     = led_q;
    mmio_rd_s = 32'h0000_0000;
    if (hit_s && is_word_s && !misalign_s) begin
      case (addr[15:0])
        16'h0000: begin
          mmio_rd_s = {16'h0000, led_q};
          if (mem_w) led_d = din[15:0];
          else       led_d = led_q;
        end
        16'h0004: mmio_rd_s = {16'h0000, sw_sync_q};
        default:  mmio_rd_s = 32'h0000_0000;
      endcase
    end else begin
      mmio_rd_s = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q     <= 16'h0000;
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign led_out = led_q;
`else
  logic unused_cfg_s;
  assign hit_s        = 1'b0;
  assign mmio_rd_s    = 32'h0000_0000;
  assign unused_cfg_s = ^MMIO_BASE;
`endif

  assign dout     = misalign_s ? 32'h0000_0000 : (hit_s ? mmio_rd_s : ram_rd_s);
  assign misalign = misalign_s;

  // The first misaligned address is captured only while the counter is still zero.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (misalign_s) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      else                    err_cnt_d = err_cnt_q;
      if (err_cnt_q == 8'h00) err_addr_d = addr;
      else                    err_addr_d = err_addr_q;
    end else begin
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q  <= 8'h00;
      err_addr_q <= 32'h0000_0000;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: directed cases plus randomized traffic checked
// against a byte-addressed reference memory.
module tb_dmem_unit;
  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst, mem_w, misalign;
  logic [31:0] addr, din, dout, err_addr;
  logic [2:0]  dm_ctrl;
  logic [7:0]  err_cnt;
`ifdef DMEM_MMIO_EN
  logic [15:0] sw_in, led_out;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [64];
  int          ref_cnt = 0;
  logic [31:0] ref_eaddr = 32'h0;
  logic [31:0] seen;

  dmem_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .addr(addr), .din(din), .dm_ctrl(dm_ctrl),
    .dout(dout), .misalign(misalign), .err_cnt(err_cnt), .err_addr(err_addr)
`ifdef DMEM_MMIO_EN
    , .sw_in(sw_in), .led_out(led_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ref_mis(input logic [31:0] a, input logic [2:0] c);
    if (c == 3'd0) return (a % 4) != 0;
    if (c == 3'd1 || c == 3'd2) return (a % 2) != 0;
    return 1'b0;
  endfunction

  // Loads built byte by byte from the reference array, extension done arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
    int          b;
    int          wb;
    logic [31:0] v;
    b  = int'(a % 64);
    wb = b - (b % 4);
    if (ref_mis(a, c)) return 32'h0;
    case (c)
      3'd0: v = {ref_mem[wb+3], ref_mem[wb+2], ref_mem[wb+1], ref_mem[wb]};
      3'd1, 3'd2: begin
        v = ref_mem[b+1] * 32'd256 + ref_mem[b];
        if (c == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      3'd3, 3'd4: begin
        v = {24'h0, ref_mem[b]};
        if (c == 3'd3 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] c, input logic r, input bit chk,
                       output logic [31:0] obs);
    logic mis, hit;
    int   b;
    @(negedge clk);
    mem_w = w; addr = a; din = d; dm_ctrl = c; rst = r;
    #1;
    obs = dout;
    mis = ref_mis(a, c);
`ifdef DMEM_MMIO_EN
    hit = (a[31:16] == 16'hFFFF);
`else
    hit = 1'b0;
`endif
    check_eq("misalign", {31'b0, misalign}, {31'b0, mis});
    if (chk && !hit) check_eq("dout", dout, ref_load(a, c));
    @(posedge clk);
    #1;
    if (!r) begin
      ref_cnt   = 0;
      ref_eaddr = 32'h0;
    end else begin
      if (mis) begin
        if (ref_cnt == 0) ref_eaddr = a;
        ref_cnt++;
      end
      b = int'(a % 64);
      if (w && !mis && !hit) begin
        case (c)
          3'd0: for (int k = 0; k < 4; k++) ref_mem[b+k] = d[8*k +: 8];
          3'd1, 3'd2: begin ref_mem[b] = d[7:0]; ref_mem[b+1] = d[15:8]; end
          3'd3, 3'd4: ref_mem[b] = d[7:0];
          default: ;
        endcase
      end
    end
    check_eq("err_cnt", {24'b0, err_cnt}, (ref_cnt > 255) ? 32'd255 : 32'(ref_cnt));
    check_eq("err_addr", err_addr, ref_eaddr);
  endtask

  initial begin
    rst = 1'b0; mem_w = 1'b0; addr = 32'h0; din = 32'h0; dm_ctrl = 3'b111;
`ifdef DMEM_MMIO_EN
    sw_in = 16'h0000;
`endif
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 3'b111, 1'b0, 1'b0, seen);
    check_eq("reset_cnt", {24'b0, err_cnt}, 32'h0);
    check_eq("reset_eaddr", err_addr, 32'h0);

    for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i * 4), $urandom, 3'd0, 1'b1, 1'b0, seen);

    cycle(1'b1, 32'h10, 32'h8000_00F0, 3'd0, 1'b1, 1'b1, seen);
    cycle(1'b0, 32'h10, 32'h0, 3'd0, 1'b1, 1'b1, seen); check_eq("lw_10", seen, 32'h8000_00F0);
    cycle(1'b0, 32'h13, 32'h0, 3'd3, 1'b1, 1'b1, seen); check_eq("lb_13", seen, 32'hFFFF_FF80);
    cycle(1'b0, 32'h13, 32'h0, 3'd4, 1'b1, 1'b1, seen); check_eq("lbu_13", seen, 32'h0000_0080);
    cycle(1'b1, 32'h10, 32'h1122_3344, 3'd0, 1'b1, 1'b1, seen);
    cycle(1'b1, 32'h11, 32'h0000_00AA, 3'd3, 1'b1, 1'b1, seen);
    cycle(1'b0, 32'h10, 32'h0, 3'd0, 1'b1, 1'b1, seen); check_eq("sb_11", seen, 32'h1122_AA44);
    cycle(1'b1, 32'h12, 32'h0000_BEEF, 3'd1, 1'b1, 1'b1, seen);
    cycle(1'b0, 32'h10, 32'h0, 3'd0, 1'b1, 1'b1, seen); check_eq("sh_12", seen, 32'hBEEF_AA44);
    cycle(1'b0, 32'h12, 32'h0, 3'd1, 1'b1, 1'b1, seen); check_eq("lh_12", seen, 32'hFFFF_BEEF);
    cycle(1'b0, 32'h12, 32'h0, 3'd2, 1'b1, 1'b1, seen); check_eq("lhu_12", seen, 32'h0000_BEEF);
    cycle(1'b1, 32'h10, 32'hCAFE_F00D, 3'd0, 1'b1, 1'b1, seen); check_eq("rdw_old", seen, 32'hBEEF_AA44);
    cycle(1'b0, 32'h10, 32'h0, 3'd0, 1'b1, 1'b1, seen); check_eq("rdw_new", seen, 32'hCAFE_F00D);

    cycle(1'b1, 32'h21, 32'h5555_5555, 3'd0, 1'b1, 1'b1, seen);
    check_eq("mis_dout", seen, 32'h0);
    check_eq("mis_cnt1", {24'b0, err_cnt}, 32'd1);
    check_eq("mis_eaddr1", err_addr, 32'h21);
    cycle(1'b0, 32'h20, 32'h0, 3'd0, 1'b1, 1'b1, seen);
    cycle(1'b0, 32'h33, 32'h0, 3'd1, 1'b1, 1'b1, seen);
    check_eq("mis_cnt2", {24'b0, err_cnt}, 32'd2);
    check_eq("mis_eaddr2", err_addr, 32'h21);
    cycle(1'b1, 32'h0000_0020, 32'h0, 3'd6, 1'b1, 1'b1, seen); check_eq("illegal_dout", seen, 32'h0);

    cycle(1'b1, 32'h1008, 32'h1234_5678, 3'd0, 1'b1, 1'b1, seen);
    cycle(1'b0, 32'h8, 32'h0, 3'd0, 1'b1, 1'b1, seen); check_eq("wrap", seen, 32'h1234_5678);
    cycle(1'b1, 32'h8, 32'hDEAD_BEEF, 3'd0, 1'b0, 1'b1, seen);
    check_eq("rst_cnt", {24'b0, err_cnt}, 32'h0);
    cycle(1'b0, 32'h8, 32'h0, 3'd0, 1'b1, 1'b1, seen); check_eq("rst_drop", seen, 32'h1234_5678);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), $urandom & 32'h7FFF_F03F, $urandom,
            3'($urandom_range(0, 7)), ($urandom_range(0, 31) != 0), 1'b1, seen);

    cycle(1'b0, 32'h0, 32'h0, 3'b111, 1'b0, 1'b1, seen);
    for (int i = 0; i < 300; i++) cycle(1'b0, 32'h2, 32'h0, 3'd0, 1'b1, 1'b1, seen);
    check_eq("sat_cnt", {24'b0, err_cnt}, 32'hFF);
    check_eq("sat_eaddr", err_addr, 32'h2);

`ifdef DMEM_MMIO_EN
    cycle(1'b1, 32'hFFFF_0000, 32'h0001_A5A5, 3'd0, 1'b1, 1'b1, seen);
    check_eq("led_out", {16'h0, led_out}, 32'h0000_A5A5);
    cycle(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b1, seen);
    sw_in = 16'h00C3;
    cycle(1'b0, 32'h4, 32'h0, 3'd0, 1'b1, 1'b1, seen);
    cycle(1'b0, 32'h4, 32'h0, 3'd0, 1'b1, 1'b1, seen);
    cycle(1'b0, 32'hFFFF_0004, 32'h0, 3'd0, 1'b1, 1'b1, seen);
    check_eq("sw_sync", seen, 32'h0000_00C3);
    cycle(1'b0, 32'hFFFF_0000, 32'h0, 3'd1, 1'b1, 1'b1, seen);
    check_eq("mmio_half", seen, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
